// File: rtl/fft_session_ctrl_pkg.sv
// Shared definitions for the FFT session controller: FSM states and mode-to-size helpers.
package fft_session_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_COMPUTE,
        S_DRAIN
    } state_t;

    function automatic int mode_size(input int min_size, input int m);
        return min_size << m;
    endfunction

    // The mode index is range-checked first, so an oversized shift never reaches the size compare.
    function automatic logic mode_legal(input int m, input int mode_num,
                                        input int min_size, input int max_size);
        return (m < mode_num) && (mode_size(min_size, m) <= max_size);
    endfunction

endpackage

// File: rtl/fft_out_buffer.sv
// Result drain: issues memory reads in natural order, aligns the 1-cycle read latency
// and presents each sample through a single valid/ready holding register.
module fft_out_buffer #(
    parameter int SW = 8,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_en,
    input  logic [AW:0]   i_last_idx,
    input  logic [SW-1:0] i_rdata,
    input  logic          i_ready,
    output logic [AW-1:0] o_rd_addr,
    output logic [SW-1:0] o_data,
    output logic          o_valid,
    output logic          o_last
);

    logic [AW:0]   r_idx;
    logic          r_pend;
    logic          r_pend_last;
    logic          r_vld;
    logic          r_last;
    logic [SW-1:0] r_data;
    logic          w_issue;

    // A new read may go out in the same cycle the held sample leaves, so the slot is free on return.
    assign w_issue   = i_en && !r_pend && (r_idx <= i_last_idx) && (!r_vld || i_ready);
    assign o_rd_addr = r_idx[AW-1:0];
    assign o_valid   = r_vld && i_en;
    assign o_last    = o_valid && r_last;
    assign o_data    = o_valid ? r_data : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx       <= '0;
            r_pend      <= 1'b0;
            r_pend_last <= 1'b0;
            r_vld       <= 1'b0;
            r_last      <= 1'b0;
        end else if (!i_en) begin
            r_idx       <= '0;
            r_pend      <= 1'b0;
            r_pend_last <= 1'b0;
            r_vld       <= 1'b0;
            r_last      <= 1'b0;
        end else begin
            r_pend <= w_issue;
            if (w_issue) begin
                r_idx       <= r_idx + 1'b1;
                r_pend_last <= (r_idx == i_last_idx);
            end
            if (r_pend) begin
                r_vld  <= 1'b1;
                r_last <= r_pend_last;
            end else if (r_vld && i_ready) begin
                r_vld  <= 1'b0;
                r_last <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (r_pend) begin
            r_data <= i_rdata;
        end
    end

endmodule

// File: rtl/fft_session_ctrl.sv
// FFT session controller: mode latch, bit-reversed sample load, engine handoff with
// watchdog, and back-pressured natural-order drain; abort returns to IDLE without reset.
module fft_session_ctrl #(
    parameter  int BIT_WIDTH    = 4,
    parameter  int FFT_MAX_SIZE = 16,
    parameter  int MODE_NUM     = 3,
    parameter  int MIN_SIZE     = 4,
    parameter  int TIMEOUT      = 1023,
    localparam int SW           = 2 * BIT_WIDTH,
    localparam int AW           = $clog2(FFT_MAX_SIZE),
    localparam int MW           = (MODE_NUM > 1) ? $clog2(MODE_NUM) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [MW-1:0] cfg_mode,
    input  logic          start,
    input  logic          abort,
    input  logic [SW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [SW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_last,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [MW-1:0] mode,
    output logic          mem_wr_en,
    output logic          mem_bit_rev_en,
    output logic [AW-1:0] mem_addr,
    output logic [SW-1:0] mem_wdata,
    input  logic [SW-1:0] mem_rdata,
    output logic          eng_init,
    input  logic          eng_ready,
    input  logic          eng_wr_en,
    input  logic [AW-1:0] eng_addr,
    input  logic [SW-1:0] eng_wdata
);
    import fft_session_ctrl_pkg::*;

    localparam int WDW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int WD_LIM = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    state_t        r_state;
    logic [AW:0]   r_cnt;
    logic [AW:0]   r_nm1;
    logic [MW-1:0] r_mode;
    logic          r_err;
    logic          r_in_ready;
    logic          r_eng_init;
    logic          r_busy;
    logic [WDW-1:0] r_wdog;

    logic          w_start_ok;
    logic          w_load_acc;
    logic          w_wd_fire;
    logic          w_wd_abort;
    logic          w_last_acc;
    logic          w_to_idle;
    logic [AW-1:0] w_rd_addr;
    logic          w_out_valid;
    logic          w_out_last;

    assign w_start_ok = mode_legal(int'(cfg_mode), MODE_NUM, MIN_SIZE, FFT_MAX_SIZE);
    assign w_load_acc = in_valid && r_in_ready;
    // r_wdog counts COMPUTE cycles already spent; the engine gets TIMEOUT cycles of eng_init.
    assign w_wd_fire  = (TIMEOUT != 0) && (r_wdog == WDW'(WD_LIM));
    assign w_wd_abort = (r_state == S_COMPUTE) && !abort && w_wd_fire;
    assign w_last_acc = (r_state == S_DRAIN) && w_out_valid && out_ready && w_out_last;
    assign w_to_idle  = (r_state != S_IDLE) && (abort || w_wd_abort || w_last_acc);

    assign in_ready  = r_in_ready;
    assign eng_init  = r_eng_init;
    assign busy      = r_busy;
    assign err       = r_err;
    assign mode      = r_mode;
    assign out_valid = w_out_valid;
    assign out_last  = w_out_last;
    assign done      = w_last_acc && !abort;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_nm1      <= '0;
            r_mode     <= '0;
            r_err      <= 1'b0;
            r_in_ready <= 1'b0;
            r_eng_init <= 1'b0;
            r_busy     <= 1'b0;
            r_wdog     <= '0;
        end else if (w_to_idle) begin
            r_state    <= S_IDLE;
            r_in_ready <= 1'b0;
            r_eng_init <= 1'b0;
            r_busy     <= 1'b0;
            if (w_wd_abort) begin
                r_err <= 1'b1;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start && !abort) begin
                        if (w_start_ok) begin
                            r_mode     <= cfg_mode;
                            r_err      <= 1'b0;
                            r_cnt      <= '0;
                            r_nm1      <= (AW+1)'(mode_size(MIN_SIZE, int'(cfg_mode)) - 1);
                            r_state    <= S_LOAD;
                            r_in_ready <= 1'b1;
                            r_busy     <= 1'b1;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    if (w_load_acc) begin
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == r_nm1) begin
                            r_state    <= S_COMPUTE;
                            r_in_ready <= 1'b0;
                            r_eng_init <= 1'b1;
                            r_wdog     <= '0;
                        end
                    end
                end
                S_COMPUTE: begin
                    if (eng_ready) begin
                        r_state    <= S_DRAIN;
                        r_eng_init <= 1'b0;
                    end else begin
                        r_wdog <= r_wdog + 1'b1;
                    end
                end
                S_DRAIN: begin
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        mem_wr_en      = 1'b0;
        mem_bit_rev_en = 1'b0;
        mem_addr       = '0;
        mem_wdata      = '0;
        case (r_state)
            S_LOAD: begin
                mem_wr_en      = w_load_acc;
                mem_bit_rev_en = w_load_acc;
                mem_addr       = r_cnt[AW-1:0];
                mem_wdata      = in_data;
            end
            S_COMPUTE: begin
                mem_wr_en = eng_wr_en;
                mem_addr  = eng_addr;
                mem_wdata = eng_wdata;
            end
            S_DRAIN: mem_addr = w_rd_addr;
            default: ;
        endcase
    end

    fft_out_buffer #(
        .SW (SW),
        .AW (AW)
    ) u_out_buffer (
        .clk        (clk),
        .rst        (rst),
        .i_en       (r_state == S_DRAIN),
        .i_last_idx (r_nm1),
        .i_rdata    (mem_rdata),
        .i_ready    (out_ready),
        .o_rd_addr  (w_rd_addr),
        .o_data     (out_data),
        .o_valid    (w_out_valid),
        .o_last     (w_out_last)
    );

endmodule

// File: tb/tb_fft_session_ctrl.sv
// Randomized bench for fft_session_ctrl: sessions against a memory/engine model and a
// reference of expected results computed from the bit-reversal load rule.
module tb_fft_session_ctrl;

    localparam int MINN = 4;
    localparam int TO   = 20;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] cfg_mode;
    logic       start, abort;
    logic [7:0] in_data;
    logic       in_valid, in_ready;
    logic [7:0] out_data;
    logic       out_valid, out_ready, out_last;
    logic       busy, done, err;
    logic [1:0] mode;
    logic       mem_wr_en, mem_bit_rev_en;
    logic [3:0] mem_addr;
    logic [7:0] mem_wdata, mem_rdata;
    logic       eng_init, eng_ready, eng_wr_en;
    logic [3:0] eng_addr;
    logic [7:0] eng_wdata;

    int n_chk, n_fail;
    logic [7:0] mem [16];

    always #5 clk = ~clk;

    fft_session_ctrl #(
        .BIT_WIDTH    (4),
        .FFT_MAX_SIZE (16),
        .MODE_NUM     (3),
        .MIN_SIZE     (MINN),
        .TIMEOUT      (TO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .cfg_mode       (cfg_mode),
        .start          (start),
        .abort          (abort),
        .in_data        (in_data),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_last       (out_last),
        .busy           (busy),
        .done           (done),
        .err            (err),
        .mode           (mode),
        .mem_wr_en      (mem_wr_en),
        .mem_bit_rev_en (mem_bit_rev_en),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .eng_init       (eng_init),
        .eng_ready      (eng_ready),
        .eng_wr_en      (eng_wr_en),
        .eng_addr       (eng_addr),
        .eng_wdata      (eng_wdata)
    );

    function automatic logic [3:0] brev(input logic [3:0] a, input int l);
        logic [3:0] r;
        r = '0;
        for (int i = 0; i < l; i++) r[l-1-i] = a[i];
        return r;
    endfunction

    // fft_memory stand-in: bit reversal over log2(N) bits of the latched mode, synchronous read.
    always @(posedge clk) begin
        if (mem_wr_en)
            mem[mem_bit_rev_en ? brev(mem_addr, 2 + int'(mode)) : mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    function automatic logic [63:0] outs();
        return {33'd0, busy, in_ready, out_valid, out_last, done, err, eng_init,
                mem_wr_en, mem_bit_rev_en, mode, mem_addr, mem_wdata, out_data};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic session(input int m, input int vpct, input int rpct, input int lat,
                           input int ab_ld, input int ab_dr, input bit do_rst);
        int n, k, idx, g, c, j, cyc;
        logic [7:0] smp [16];
        logic [7:0] expv [16];
        logic [7:0] v, pd;
        bit stall, acc;
        n = MINN << m;
        for (int i = 0; i < n; i++) smp[i] = 8'($urandom);
        for (int i = 0; i < n; i++) expv[i] = smp[brev(4'(i), 2 + m)];
        j = $urandom_range(0, n - 1);
        v = 8'($urandom);

        cfg_mode = 2'(m); start = 1'b1;
        tick;
        start = 1'b0; cfg_mode = 2'($urandom);
        #1;
        chk("st_busy", busy, 1); chk("st_err", err, 0); chk("st_mode", mode, m);

        k = 0; g = 0;
        while (k < n) begin
            in_valid = ($urandom_range(0, 99) < vpct) || (k == ab_ld);
            in_data  = smp[k];
            abort    = in_valid && (k == ab_ld);
            start    = (g == 0);
            cfg_mode = 2'd3;
            #1;
            chk("ld_rdy", in_ready, 1); chk("ld_we", mem_wr_en, in_valid);
            chk("ld_err", err, 0); chk("ld_mode", mode, m);
            if (in_valid) begin
                chk("ld_addr", mem_addr, k); chk("ld_brev", mem_bit_rev_en, 1);
                chk("ld_wd", mem_wdata, smp[k]);
            end
            tick;
            start = 1'b0;
            if (in_valid) k++;
            if (abort) begin
                abort = 1'b0; in_valid = 1'b0;
                #1;
                chk("abl_busy", busy, 0); chk("abl_rdy", in_ready, 0);
                chk("abl_done", done, 0); chk("abl_err", err, 0);
                return;
            end
            g++;
            if (g > 400) begin chk("ld_timeout", 0, 1); return; end
        end
        in_valid = 1'b0;

        if (lat < 0) begin
            c = 0;
            for (g = 0; g < 60; g++) begin
                #1;
                if (!eng_init) break;
                c++;
                tick;
            end
            chk("wd_cycles", c, TO); chk("wd_busy", busy, 0); chk("wd_err", err, 1);
            chk("wd_done", done, 0); chk("wd_init", eng_init, 0);
            return;
        end

        for (c = 1; c <= lat; c++) begin
            eng_wr_en = (c == 1);
            eng_addr  = (c == 1) ? 4'(j) : 4'($urandom);
            eng_wdata = (c == 1) ? v : 8'($urandom);
            #1;
            chk("cp_init", eng_init, 1); chk("cp_rdy", in_ready, 0);
            chk("cp_we", mem_wr_en, eng_wr_en); chk("cp_addr", mem_addr, eng_addr);
            chk("cp_wd", mem_wdata, eng_wdata); chk("cp_brev", mem_bit_rev_en, 0);
            if (do_rst && c == 2) begin
                rst = 1'b1;
                #1;
                chk("rst_outs", outs(), 0);
                tick;
                rst = 1'b0; eng_wr_en = 1'b0;
                return;
            end
            tick;
        end
        eng_wr_en = 1'b0;
        expv[j] = v;
        eng_ready = 1'b1;
        #1;
        chk("rdy_init", eng_init, 1);
        tick;
        eng_ready = 1'b0;

        idx = 0; g = 0; stall = 0; pd = '0; cyc = 0;
        while (idx < n) begin
            out_ready = ($urandom_range(0, 99) < rpct);
            abort     = out_valid && (idx == ab_dr);
            #1;
            chk("dr_busy", busy, 1); chk("dr_init", eng_init, 0); chk("dr_we", mem_wr_en, 0);
            if (stall) begin
                chk("hold_v", out_valid, 1); chk("hold_d", out_data, pd);
            end
            if (out_valid) begin
                chk("dr_data", out_data, expv[idx]); chk("dr_last", out_last, idx == n - 1);
            end
            chk("dr_done", done, out_valid && out_ready && (idx == n - 1) && !abort);
            stall = out_valid && !out_ready;
            pd    = out_data;
            acc   = out_valid && out_ready;
            tick;
            cyc++;
            if (acc) idx++;
            if (abort) begin
                abort = 1'b0; out_ready = 1'b0;
                #1;
                chk("abd_busy", busy, 0); chk("abd_vld", out_valid, 0);
                chk("abd_done", done, 0); chk("abd_err", err, 0);
                return;
            end
            g++;
            if (g > 400) begin chk("dr_timeout", 0, 1); return; end
        end
        out_ready = 1'b0;
        #1;
        chk("end_busy", busy, 0); chk("end_vld", out_valid, 0); chk("end_done", done, 0);
        if (rpct >= 100) chk("thru", cyc <= 2 * n + 2, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        n_chk = 0; n_fail = 0;
        rst = 1'b1; start = 1'b0; abort = 1'b0; cfg_mode = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        eng_ready = 1'b0; eng_wr_en = 1'b0; eng_addr = 4'hA; eng_wdata = 8'h5C;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        #2;
        chk("rst_outs0", outs(), 0);
        tick; tick;
        rst = 1'b0;
        tick;

        session(0, 100, 100, 10, -1, -1, 1'b0);
        session(2, 50, 50, $urandom_range(1, 15), -1, -1, 1'b0);

        cfg_mode = 2'd3; start = 1'b1;
        tick;
        start = 1'b0;
        #1;
        chk("bad_err", err, 1); chk("bad_busy", busy, 0);
        session(1, 100, 100, 3, -1, -1, 1'b0);

        cfg_mode = 2'd0; start = 1'b1; abort = 1'b1;
        tick;
        start = 1'b0; abort = 1'b0;
        #1;
        chk("abst_busy", busy, 0);

        session(1, 100, 100, 4, 2, -1, 1'b0);
        session(1, 100, 100, 4, -1, 1, 1'b0);
        session(1, 70, 70, 5, -1, -1, 1'b0);

        session(0, 100, 100, -1, -1, -1, 1'b0);
        session(0, 100, 100, 2, -1, -1, 1'b0);

        session(1, 100, 100, 6, -1, -1, 1'b1);
        session(1, 100, 100, 6, -1, -1, 1'b0);

        for (int i = 0; i < 12; i++)
            session($urandom_range(0, 2), $urandom_range(30, 100), $urandom_range(30, 100),
                    $urandom_range(1, 15), -1, -1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
